// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx shared definitions: FSM states,
// default baud divider and the oversample factor.
package fifo_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    localparam int OVERSAMPLE = 16;
    localparam int DEF_DVSR   = 163;
    localparam int DEF_DVSR_W = 8;

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// Mod-DVSR oversample tick generator with sync clear,
// shared by the UART transmitter and receiver.
module fifo_uart_tx_baud_gen
    import fifo_uart_tx_pkg::*;
#(
    parameter int DVSR   = DEF_DVSR,
    parameter int DVSR_W = DEF_DVSR_W
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic s_tick
);

    localparam logic [DVSR_W-1:0] LAST = DVSR_W'(DVSR - 1);

    logic [DVSR_W-1:0] cnt;

    // wrap at DVSR-1; clr re-phases the count to a frame start
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign s_tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed 8N1 UART transmitter: pops a fall-through
// FIFO word in IDLE and shifts it out LSB first.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = DEF_DVSR,
    parameter int DVSR_W  = DEF_DVSR_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_r_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int TICK_W =
        $clog2(SB_TICK > OVERSAMPLE ? SB_TICK : OVERSAMPLE);
    localparam int BIT_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [TICK_W-1:0] OS_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] SB_LAST = TICK_W'(SB_TICK - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DBIT - 1);

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DBIT-1:0]   sreg_q, sreg_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              pop;
    logic              s_tick;

    // a pop is only offered from IDLE and never while in reset
    assign pop = (state_q == IDLE) && !fifo_empty && !reset;

    fifo_uart_tx_baud_gen #(
        .DVSR   (DVSR),
        .DVSR_W (DVSR_W)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .clr    (pop),
        .s_tick (s_tick)
    );

    // state and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // next state; tx_d is the line level of the next cycle
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        sreg_d  = sreg_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    state_d = START;
                    tick_d  = '0;
                    sreg_d  = fifo_r_data;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == OS_LAST) begin
                        state_d = DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                        tx_d    = sreg_q[0];
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_d = '0;
                        sreg_d = sreg_q >> 1;
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            bit_d = bit_q + 1'b1;
                            tx_d  = sreg_d[0];
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tick_q == SB_LAST) begin
                        state_d = IDLE;
                        tick_d  = '0;
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_rd      = pop;
    assign tx           = tx_q;
    assign tx_busy      = (state_q != IDLE);
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at DVSR=4
// (64-clk bits), SB_TICK 16 and 32 instances.
module tb_fifo_uart_tx;

    localparam int DV  = 4;
    localparam int BIT = 16 * DV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fifo_empty;
    logic [7:0] fifo_r_data;
    logic       fifo_rd, tx, tx_busy, tx_done_tick;

    logic       e32 = 1'b1;
    logic [7:0] d32 = 8'h00;
    logic       rd32, tx32, busy32, done32;

    int checks = 0;
    int failures = 0;

    int         pops = 0;
    int         base = 0;
    int         src_n = 0;
    int         head;
    logic [7:0] src [4];
    logic       ovr = 1'b0;
    logic       ovr_empty = 1'b1;
    logic [7:0] ovr_data = 8'h00;

    always #5 clk = ~clk;

    assign head = pops - base;

    // FIFO read-port model: fall-through head of a small list
    always_comb begin
        fifo_empty  = 1'b1;
        fifo_r_data = 8'h00;
        if (ovr) begin
            fifo_empty  = ovr_empty;
            fifo_r_data = ovr_data;
        end else if (head < src_n) begin
            fifo_empty  = 1'b0;
            fifo_r_data = src[head[1:0]];
        end
    end

    // count pops seen by the FIFO
    always @(posedge clk) begin
        if (fifo_rd) pops <= pops + 1;
    end

    fifo_uart_tx #(
        .DBIT(8), .SB_TICK(16), .DVSR(DV), .DVSR_W(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_r_data  (fifo_r_data),
        .fifo_rd      (fifo_rd),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    fifo_uart_tx #(
        .DBIT(8), .SB_TICK(32), .DVSR(DV), .DVSR_W(8)
    ) dut32 (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (e32),
        .fifo_r_data  (d32),
        .fifo_rd      (rd32),
        .tx           (tx32),
        .tx_busy      (busy32),
        .tx_done_tick (done32)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input int n);
        src[0] = a;
        src[1] = b;
        src[2] = c;
        src[3] = 8'h00;
        base   = pops;
        src_n  = n;
    endtask

    task automatic wait_pop(input bit use32, input int budget,
                            input string tag);
        int n = 0;
        #1;
        while ((use32 ? rd32 : fifo_rd) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, use32 ? rd32 : fifo_rd, 1'b1);
    endtask

    // call from the pop cycle; returns at the done cycle negedge
    task automatic check_frame(input logic [7:0] b, input int sb,
                               input bit use32, input string tag);
        int frame = 9 * BIT + sb * DV;
        int bad = 0;
        int extra = 0;
        int idx;
        logic [7:0] rx = 8'h00;
        logic t, e, ctl;
        for (int k = 1; k <= frame; k++) begin
            @(negedge clk);
            t   = use32 ? tx32 : tx;
            idx = (k - 1) / BIT;
            if (idx == 0)
                e = 1'b0;
            else if (idx <= 8)
                e = b[idx-1];
            else
                e = 1'b1;
            if (t !== e) bad++;
            if ((k - 1) % BIT == BIT / 2 && idx >= 1 && idx <= 8)
                rx[idx-1] = t;
            ctl = use32 ? (rd32 | done32 | ~busy32)
                        : (fifo_rd | tx_done_tick | ~tx_busy);
            if (ctl !== 1'b0) extra++;
        end
        chk({tag, "_bits"}, bad, 0);
        chk({tag, "_rx"}, rx, b);
        chk({tag, "_ctl"}, extra, 0);
        @(negedge clk);
        chk({tag, "_done"}, use32 ? done32 : tx_done_tick, 1);
        chk({tag, "_tx"}, use32 ? tx32 : tx, 1);
        chk({tag, "_busy"}, use32 ? busy32 : tx_busy, 0);
    endtask

    initial begin
        int bad;
        int p0;

        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done_tick, 0);
        chk("rst_rd", fifo_rd, 0);
        reset = 1'b0;

        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_rd !== 1'b0 ||
                tx_busy !== 1'b0 || tx_done_tick !== 1'b0)
                bad++;
        end
        chk("idle_quiet", bad, 0);
        chk("idle_pops", pops, 0);

        load(8'hA5, 8'h00, 8'h00, 1);
        wait_pop(0, 10, "a5_pop");
        p0 = pops;
        check_frame(8'hA5, 16, 0, "a5");
        chk("a5_nopop", fifo_rd, 0);
        chk("a5_pops", pops - p0, 1);

        load(8'h00, 8'hFF, 8'h3C, 3);
        wait_pop(0, 10, "b2b_pop0");
        p0 = pops;
        check_frame(8'h00, 16, 0, "b2b0");
        chk("b2b_pop1", fifo_rd, 1);
        check_frame(8'hFF, 16, 0, "b2b1");
        chk("b2b_pop2", fifo_rd, 1);
        check_frame(8'h3C, 16, 0, "b2b2");
        chk("b2b_nopop", fifo_rd, 0);
        chk("b2b_pops", pops - p0, 3);

        load(8'h5A, 8'hC3, 8'h00, 2);
        wait_pop(0, 10, "mrst_pop");
        p0 = pops;
        repeat (300) @(negedge clk);
        chk("mrst_busy_pre", tx_busy, 1);
        reset = 1'b1;
        #1;
        chk("mrst_tx", tx, 1);
        chk("mrst_busy", tx_busy, 0);
        chk("mrst_rd", fifo_rd, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_rd !== 1'b0 || tx_busy !== 1'b0)
                bad++;
        end
        chk("mrst_hold", bad, 0);
        chk("mrst_pops", pops - p0, 1);
        reset = 1'b0;
        #1;
        chk("mrst_rd_rel", fifo_rd, 1);
        check_frame(8'hC3, 16, 0, "mrst");
        chk("mrst_pops2", pops - p0, 2);

        d32 = 8'h96;
        e32 = 1'b0;
        wait_pop(1, 10, "sb32_pop");
        @(posedge clk);
        #1 e32 = 1'b1;
        check_frame(8'h96, 32, 1, "sb32");
        chk("sb32_nopop", rd32, 0);

        ovr_data  = 8'h81;
        ovr_empty = 1'b0;
        ovr       = 1'b1;
        wait_pop(0, 10, "ovr_pop");
        p0 = pops;
        @(posedge clk);
        #1 ovr_empty = 1'b1;
        fork
            check_frame(8'h81, 16, 0, "ovr");
            begin
                repeat (100) @(posedge clk);
                ovr_empty = 1'b0;
                ovr_data  = 8'h7E;
                repeat (150) @(posedge clk);
                ovr_empty = 1'b1;
                repeat (50) @(posedge clk);
                ovr_empty = 1'b0;
                ovr_data  = 8'h00;
                repeat (200) @(posedge clk);
                ovr_empty = 1'b1;
            end
        join
        chk("ovr_pops", pops - p0, 1);
        ovr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer of the team's synchronous FIFO. It drains bytes from the FIFO's first-word-fall-through read port and serializes each one as an 8N1-style UART frame on a single tx line. The block sits between the transmit FIFO and the board-level serial pin and owns its own 16x-oversample baud tick generator.

Parameters:
DBIT, 8, data bits per frame; also the width of fifo_r_data.
SB_TICK, 16, stop-bit length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
DVSR, 163, clk cycles per oversample tick (50 MHz / (16*19200)); legal range >= 1.
DVSR_W, 8, width of the baud counter; must satisfy 2**DVSR_W >= DVSR.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high.
fifo_empty  in  1  FIFO empty flag; fifo_r_data is valid whenever this is low.
fifo_r_data  in  DBIT  head-of-FIFO word (combinational, fall-through).
fifo_rd  out  1  pop strobe to the FIFO, one clk wide.
tx  out  1  serial output, idle high.
tx_busy  out  1  high while a frame is in progress (state != IDLE).
tx_done_tick  out  1  one-clk pulse when a frame completes.

Behaviour:
- Reset (async, high): state = IDLE, tx = 1, fifo_rd = 0, tx_busy = 0, tx_done_tick = 0, baud counter = 0, shift register = 0. Reset mid-frame aborts the frame. tx returns high immediately. The byte already popped is lost and no extra pop occurs.
- Baud generator: mod-DVSR counter. s_tick is high in the cycle the counter equals DVSR-1. The counter is synchronously cleared to 0 in the pop cycle, so every bit is phase-aligned to the frame start.
- FSM states: IDLE, START, DATA, STOP. It uses a tick counter (0..15 in START/DATA, 0..SB_TICK-1 in STOP) and a bit counter (0..DBIT-1).
- IDLE: tx = 1. If fifo_empty = 0, the block asserts fifo_rd combinationally in that cycle (T), loads fifo_r_data into the shift register and goes to START. fifo_rd is never asserted outside IDLE or while fifo_empty = 1.
- START: tx = 0 for 16 s_ticks, then go to DATA with the bit counter at 0.
- DATA: tx = shift register bit 0 (LSB first). After 16 s_ticks, shift right. After bit DBIT-1, go to STOP.
- STOP: tx = 1 for SB_TICK s_ticks, then go to IDLE.
- Frame timing: the tx start bit begins at cycle T+1. The frame lasts (1+DBIT)*16*DVSR + SB_TICK*DVSR clk cycles. Each bit lasts exactly 16*DVSR cycles.
- tx_done_tick: high for exactly one cycle, the first cycle back in IDLE (T+1+frame length).
- Back-to-back frames: if fifo_empty = 0 in that same done cycle, the block pops and starts the next frame. The inter-frame gap is exactly one clk of tx = 1 beyond the stop bit.
- fifo_empty and fifo_r_data are ignored outside IDLE. A FIFO write during a frame has no effect until the frame ends.
- tx is registered (no glitches). tx_busy = (state != IDLE).

Decomposition:
- Shared package: state encoding localparams (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11), default DVSR/DVSR_W, and the oversample constant 16.
- One sub-module: baud_gen. It is a mod-DVSR counter with a synchronous clear input and an s_tick output, and is reusable by the future receiver.

Test Plan:
Use DVSR = 4 for simulation, giving a bit period of 64 clk and a frame of 640 clk.
1. Idle after reset, fifo_empty = 1 for 1000 cycles -> tx = 1, fifo_rd never asserted, tx_busy = 0.
2. Push 0xA5, fifo_empty falls at cycle T -> fifo_rd = 1 only at T. tx from T+1 follows the 64-cycle bits 0,1,0,1,0,0,1,0,1,1. tx_done_tick = 1 at T+641 only.
3. Preload 0x00, 0xFF, 0x3C with fifo_empty held low -> exactly 3 pops, each frame 640 cycles, 1-cycle idle gap. A decoded sampler reads 0x00, 0xFF, 0x3C. The third done pulse is followed by no pop once empty.
4. Assert reset at T+300 during DATA for 3 cycles -> tx = 1 within the reset cycle, state IDLE, no fifo_rd. After release with fifo_empty = 0, a new frame starts cleanly.
5. SB_TICK = 32 -> stop bit high for 128 cycles, frame = 704 cycles, tx_done_tick at T+705.
6. Toggle fifo_empty and change fifo_r_data mid-frame -> no fifo_rd pulses and the transmitted byte is unchanged.
